// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants, quadrant encoding and clog2 helper for the multi-channel NCO
package dds_pkg;

  localparam int CH_TAG_W = 3;

  // Quadrant bits of the top two phase bits in quarter-wave mode
  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_NEG_BIT    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_wave_ram.sv
// rtl/dds_wave_ram.sv - DEPTH x WW waveform RAM, one write port, registered read-before-write read port
module dds_wave_ram
  import dds_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WW    = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] wa,
  input  logic [WW-1:0]           wd,
  input  logic                    re,
  input  logic [clog2(DEPTH)-1:0] ra,
  output logic [WW-1:0]           rd
);

  logic [WW-1:0] mem [DEPTH];

  // Non-blocking update gives the old word on a same-address read/write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd <= '0;
    end else begin
      if (we) mem[wa] <= wd;
      if (re) rd <= mem[ra];
    end
  end

endmodule

// File: rtl/dds_multi_nco.sv
// rtl/dds_multi_nco.sv - round-robin multi-channel NCO over a shared waveform RAM (option: DDS_MULTI_NCO_QUARTER_WAVE_EN)
module dds_multi_nco
  import dds_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WW       = 6,
  parameter int DEPTH    = 16,
  parameter int PW       = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sync,
  input  logic                    lut_we,
  input  logic [clog2(DEPTH)-1:0] lut_wa,
  input  logic [WW-1:0]           lut_wd,
  input  logic                    ftw_we,
  input  logic [CH_TAG_W-1:0]     ftw_ch,
  input  logic [PW-1:0]           ftw_data,
  output logic [WW-1:0]           out_data,
  output logic [CH_TAG_W-1:0]     out_ch,
  output logic                    out_valid
);

  localparam int AW = clog2(DEPTH);
`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
  localparam int TOPW = AW + 2;
`else
  localparam int TOPW = AW;
`endif

  typedef logic [PW-1:0] phase_t;
  typedef logic [WW-1:0] sample_t;

  phase_t              phase [CHANNELS];
  phase_t              ftw   [CHANNELS];
  logic [CH_TAG_W-1:0] sch;
  logic [TOPW-1:0]     cur_top;
  logic [AW-1:0]       rd_addr;
  logic                rd_en;
  sample_t             rd_word;

  assign rd_en = en & ~sync;

  always_comb begin
    cur_top = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sch == CH_TAG_W'(i)) cur_top = phase[i][PW-1 -: TOPW];
    end
  end

`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
  logic [1:0]    quad;
  logic [AW-1:0] idx;
  assign quad    = cur_top[AW+1:AW];
  assign idx     = cur_top[AW-1:0];
  assign rd_addr = quad[QUAD_MIRROR_BIT] ? ~idx : idx;
`else
  assign rd_addr = cur_top;
`endif

  dds_wave_ram #(.DEPTH(DEPTH), .WW(WW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .wa    (lut_wa),
    .wd    (lut_wd),
    .re    (rd_en),
    .ra    (rd_addr),
    .rd    (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        phase[i] <= '0;
        ftw[i]   <= '0;
      end
      sch       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (sync) begin
        for (int i = 0; i < CHANNELS; i++) phase[i] <= '0;
        sch <= '0;
      end else if (en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (sch == CH_TAG_W'(i)) phase[i] <= phase[i] + ftw[i];
        end
        sch    <= (sch == CH_TAG_W'(CHANNELS - 1)) ? '0 : sch + 1'b1;
        out_ch <= sch;
      end
      // Out-of-range channels match no index; same-cycle accumulate sees the old word
      if (ftw_we) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (ftw_ch == CH_TAG_W'(i)) ftw[i] <= ftw_data;
        end
      end
    end
  end

`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
  localparam sample_t HALF = sample_t'(1 << (WW - 1));
  logic neg;
  logic primed;

  // Sign flag travels with the RAM read; primed keeps out_data at 0 until the first read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg    <= 1'b0;
      primed <= 1'b0;
    end else if (rd_en) begin
      neg    <= quad[QUAD_NEG_BIT];
      primed <= 1'b1;
    end
  end

  assign out_data = !primed ? '0 : (neg ? (HALF - 1'b1 - rd_word) : (HALF + rd_word));
`else
  assign out_data = rd_word;
`endif

endmodule

// File: tb/tb_dds_multi_nco.sv
// tb/tb_dds_multi_nco.sv - self-checking bench for dds_multi_nco (directed table, corner sequences, random vs model)
module tb_dds_multi_nco;

  localparam int CH = 2, WW = 6, DEPTH = 16, PW = 8, AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, sync, lut_we, ftw_we;
  logic [AW-1:0] lut_wa;
  logic [WW-1:0] lut_wd;
  logic [2:0]    ftw_ch;
  logic [PW-1:0] ftw_data;
  logic [WW-1:0] out_data;
  logic [2:0]    out_ch;
  logic          out_valid;

  always #5 clk = ~clk;

  dds_multi_nco #(.CHANNELS(CH), .WW(WW), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .lut_we(lut_we), .lut_wa(lut_wa), .lut_wd(lut_wd),
    .ftw_we(ftw_we), .ftw_ch(ftw_ch), .ftw_data(ftw_data),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid)
  );

  int checks = 0;
  int passed = 0;

  int m_phase [CH];
  int m_ftw   [CH];
  int m_ram   [DEPTH];
  int m_sch;
  int e_data, e_ch, e_valid;

  typedef struct {
    bit en;
    bit sync;
    int v;
    int ch;
    int d;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_addr(input int ph);
`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
    int q   = ph / (1 << (PW - 2));
    int idx = (ph % (1 << (PW - 2))) / (1 << (PW - 2 - AW));
    return (q % 2 == 1) ? DEPTH - 1 - idx : idx;
`else
    return ph / (1 << (PW - AW));
`endif
  endfunction

  function automatic int model_sample(input int ph);
`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
    int half = 1 << (WW - 1);
    int w    = m_ram[model_addr(ph)];
    return (ph >= (1 << (PW - 1))) ? half - 1 - w : half + w;
`else
    return m_ram[model_addr(ph)];
`endif
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin m_phase[i] = 0; m_ftw[i] = 0; end
      for (int i = 0; i < DEPTH; i++) m_ram[i] = 0;
      m_sch = 0; e_data = 0; e_ch = 0; e_valid = 0;
    end else begin
      if (sync) begin
        for (int i = 0; i < CH; i++) m_phase[i] = 0;
        m_sch = 0; e_valid = 0;
      end else if (en) begin
        e_data  = model_sample(m_phase[m_sch]);
        e_ch    = m_sch;
        e_valid = 1;
        m_phase[m_sch] = (m_phase[m_sch] + m_ftw[m_sch]) % (1 << PW);
        m_sch = (m_sch + 1) % CH;
      end else begin
        e_valid = 0;
      end
      if (ftw_we && ftw_ch < CH) m_ftw[ftw_ch] = ftw_data;
      if (lut_we) m_ram[lut_wa] = lut_wd;
    end
  endtask

  task automatic step(input bit cmp);
    @(posedge clk);
    model_edge();
    #1;
    if (cmp) begin
      check("out_valid", out_valid, e_valid);
      check("out_ch", out_ch, e_ch);
      check("out_data", out_data, e_data);
    end
    sync = 1'b0; lut_we = 1'b0; ftw_we = 1'b0;
  endtask

  bit found;

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; lut_we = 1'b0; ftw_we = 1'b0;
    lut_wa = '0; lut_wd = '0; ftw_ch = '0; ftw_data = '0;
    step(1); step(1);
    rst_n = 1'b1;

    // Idle run with all tuning words zero: alternating tags, zero samples
    en = 1'b1;
    for (int i = 0; i < 6; i++) step(1);
    rst_n = 1'b0; step(1); rst_n = 1'b1;

    en = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      lut_we = 1'b1; lut_wa = AW'(k);
`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
      lut_wd = WW'(2 * k);
`else
      lut_wd = WW'(k);
`endif
      step(1);
    end
`ifdef DDS_MULTI_NCO_QUARTER_WAVE_EN
    ftw_we = 1'b1; ftw_ch = 3'd0; ftw_data = 8'h40; step(1);
    ftw_we = 1'b1; ftw_ch = 3'd1; ftw_data = 8'h00; step(1);
    tbl.push_back('{1, 0, 1, 0, 32});
    tbl.push_back('{1, 0, 1, 1, 32});
    tbl.push_back('{1, 0, 1, 0, 62});
    tbl.push_back('{1, 0, 1, 1, 32});
    tbl.push_back('{1, 0, 1, 0, 31});
    tbl.push_back('{1, 0, 1, 1, 32});
    tbl.push_back('{1, 0, 1, 0, 1});
`else
    ftw_we = 1'b1; ftw_ch = 3'd0; ftw_data = 8'd16; step(1);
    ftw_we = 1'b1; ftw_ch = 3'd1; ftw_data = 8'd32; step(1);
    tbl.push_back('{1, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 2});
    tbl.push_back('{1, 0, 1, 0, 2});
    tbl.push_back('{1, 0, 1, 1, 4});
    tbl.push_back('{1, 1, 0, 1, 4});
    tbl.push_back('{1, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 2});
    tbl.push_back('{0, 0, 0, 1, 2});
    tbl.push_back('{1, 0, 1, 0, 2});
`endif
    foreach (tbl[i]) begin
      en = tbl[i].en; sync = tbl[i].sync;
      step(0);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      check($sformatf("tbl%0d_ch", i), out_ch, tbl[i].ch);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].d);
    end

    // Long run through phase wrap
    en = 1'b1;
    for (int i = 0; i < 40; i++) step(1);

    // Tuning-word write to the channel scheduled in the same cycle
    for (int i = 0; i < CH && m_sch != 0; i++) step(1);
    check("sch_zero_before_ftw", m_sch, 0);
    ftw_we = 1'b1; ftw_ch = 3'd0; ftw_data = 8'd48; step(1);
    for (int i = 0; i < 10; i++) step(1);
    ftw_we = 1'b1; ftw_ch = 3'd5; ftw_data = 8'd99; step(1);
    for (int i = 0; i < 6; i++) step(1);

    // RAM write colliding with a scheduled read of the same address
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (model_addr(m_phase[m_sch]) == 3) begin
        lut_we = 1'b1; lut_wa = 4'd3; lut_wd = 6'h2A; found = 1'b1;
      end
      step(1);
    end
    check("rbw_collision_found", int'(found), 1);
    for (int i = 0; i < 40; i++) step(1);

    en = 1'b0;
    for (int i = 0; i < 4; i++) step(1);
    en = 1'b1;
    for (int i = 0; i < 8; i++) step(1);

    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      en       = ($urandom_range(0, 3) != 0);
      sync     = ($urandom_range(0, 19) == 0);
      lut_we   = ($urandom_range(0, 3) == 0);
      lut_wa   = AW'($urandom);
      lut_wd   = WW'($urandom);
      ftw_we   = ($urandom_range(0, 7) == 0);
      ftw_ch   = 3'($urandom);
      ftw_data = PW'($urandom);
      step(1);
      rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dds_multi_nco.md
Name: dds_multi_nco

Overview:
- Multi-channel numerically controlled oscillator (NCO): one phase accumulator per channel, all sharing one reprogrammable waveform RAM.
- A round-robin scheduler serves one channel per cycle and emits a tagged sample stream.
- Sits under the DDS top level and replaces the bare reprogrammable LUT. Pin muxing onto ui/uio stays in the top.

Parameters:
- CHANNELS, 4: number of NCO channels, 1..8.
- WW, 6: waveform sample width.
- DEPTH, 16: waveform RAM entries; power of 2; AW = log2(DEPTH).
- PW, 12: phase accumulator and tuning word width; PW > AW (PW >= AW+2 when quarter-wave is enabled).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  run enable; when low, accumulators and scheduler hold.
- sync  in  1  synchronous phase clear of all channels.
- lut_we  in  1  waveform RAM write strobe.
- lut_wa  in  AW  waveform RAM write address.
- lut_wd  in  WW  waveform RAM write data.
- ftw_we  in  1  tuning-word write strobe.
- ftw_ch  in  3  tuning-word target channel.
- ftw_data  in  PW  tuning word.
- out_data  out  WW  sample.
- out_ch  out  3  channel tag of out_data.
- out_valid  out  1  out_data/out_ch valid this cycle.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous, active-low on rst_n.
- Reset values: every phase, ftw and RAM word = 0; scheduler sch = 0; out_data = 0, out_ch = 0, out_valid = 0.
- Priority: rst_n > sync > en.
- Scheduler: sch counts 0..CHANNELS-1 and wraps to 0. It advances only when en=1.
- Cycle t with en=1 and no sync:
  - RAM read address = phase[sch][PW-1:PW-AW].
  - phase[sch] <= phase[sch] + ftw[sch], modulo 2^PW (wrap silently).
  - sch advances.
- Cycle t+1: out_data = RAM word read in cycle t, out_ch = that cycle's sch, out_valid = 1. Latency is 1 cycle.
- Each channel is therefore sampled once every CHANNELS cycles.
- en=0: no read, no accumulate; out_valid = 0 next cycle; out_data and out_ch hold.
- sync=1 (any en): all phase <= 0, sch <= 0, out_valid = 0 next cycle. ftw and RAM are untouched.
- RAM write: lut_we writes lut_wd at lut_wa at the clock edge, regardless of en.
  - Write and read to the same address in the same cycle: the read returns the old word (read-before-write).
- FTW write: ftw_we loads ftw[ftw_ch].
  - ftw_ch >= CHANNELS: write ignored.
  - Written channel is the one scheduled in the same cycle: the accumulate uses the old ftw; the new value applies from the next visit.
  - Phase is not cleared by an ftw write.
- lut_we and ftw_we in the same cycle: both take effect.
- Reset mid-stream: the next cycle shows out_valid = 0 and all state at reset values.

Optional Feature:
- Macro: DDS_MULTI_NCO_QUARTER_WAVE_EN.
- Defined: the RAM holds a quarter period; entries are magnitudes 0..2^(WW-1)-1.
  - Quadrant q = phase[PW-1:PW-2]; idx = phase[PW-3:PW-2-AW].
  - RAM address = q[0] ? ~idx : idx.
  - Sample = q[1] ? (2^(WW-1)-1 - word) : (2^(WW-1) + word), offset binary.
  - Sign/offset logic is registered with the read, so latency stays 1 cycle.
- Undefined: full-period lookup as above; the RAM word is output unmodified.

Decomposition:
- Package dds_pkg:
  - constant CH_TAG_W = 3;
  - clog2 function;
  - quadrant encoding constants;
  - typedefs for phase word and sample word, parametrised via localparams in the module.
- Sub-module dds_wave_ram (DEPTH x WW, one write port, one synchronous read port with read-before-write, zero reset) holds the waveform storage.
- Scheduler, accumulators and output register stay in dds_multi_nco.

Test Plan:
Configuration is CHANNELS=2, PW=8, DEPTH=16, WW=6, macro undefined, unless noted.
1. Reset then idle, en=1 with all ftw=0 -> out_valid pulses every cycle, out_ch alternates 0,1, out_data = 0.
2. RAM[k]=k for k=0..15, ftw[0]=16, ftw[1]=32, en=1 -> ch0 samples 0,1,2,...,15,0; ch1 samples 0,2,4,...,14,0 (wrap verified).
3. Running as in scenario 2, pulse sync for 1 cycle -> next cycle out_valid = 0; the following samples are ch0=0 then ch1=0; ftw unchanged.
4. ftw write to ch0 in the cycle ch0 is scheduled (16 -> 48) -> the next ch0 sample still steps by 1; later samples step by 3. Write with ftw_ch=5 -> no state change.
5. lut_we to address 3 with data 0x2A in the same cycle a read of address 3 is scheduled -> that sample = old value 3; the next read of 3 returns 0x2A. en=0 for 4 cycles -> out_valid = 0 and phases frozen.
6. With the macro defined, PW=8, RAM[i]=i*2: phase 0x00, 0x40, 0x80, 0xC0 -> samples 32, 62, 31, 1.
